io_cfg_loader: RTL

Bitstream transmitter for the IO-block configuration chain. It accepts 16-bit IO configuration words over a valid/ready handshake and serializes them MSB-first onto the daisy-chained IO blocks' configuration shift path. It drives the chain's program-mode and shift-enable controls, launches a completion token into the first block, and waits for the token to return from the last block. It sits between the top-level configuration controller and the chain of IO blocks.

---
 rtl/io_cfg_loader.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/io_cfg_loader.sv
// io_cfg_loader: serializes 16-bit IO-block configuration words MSB-first
// onto the daisy-chained IO configuration shift path, then launches a
// completion token and waits for it to come back from the last block.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start; cfg_valid ignored
// LOAD     | cfg_ready high; waiting for the next configuration word
// SHIFT    | 16 cycles of io_prgm_b=1, bit_out=sr[15], sr shifts left
// TOKEN    | one-cycle completion token into the first IO block
// WAIT_ACK | waiting for the token to return, bounded by TIMEOUT
// DONE     | one-cycle done pulse, then back to IDLE
// ERR      | token timed out; error held until start or reset
module io_cfg_loader #(
    parameter int NUM_BLOCKS = 4,
    parameter int WORD_BITS  = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WORD_BITS-1:0] cfg_data,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    output logic                 bit_out,
    output logic                 prgm_b,
    output logic                 io_prgm_b,
    output logic                 io_prgm_b_in,
    input  logic                 io_prgm_b_out,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    localparam int WCW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCW-1:0] LAST_WORD = WCW'(NUM_BLOCKS - 1);
    localparam logic [TCW-1:0] LAST_WAIT = TCW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        SHIFT    = 3'd2,
        TOKEN    = 3'd3,
        WAIT_ACK = 3'd4,
        DONE     = 3'd5,
        ERR      = 3'd6
    } state_t;

    state_t               state, state_n;
    logic [WORD_BITS-1:0] sr, sr_n;
    logic [3:0]           bcnt, bcnt_n;
    logic [WCW-1:0]       wcnt, wcnt_n;
    logic [TCW-1:0]       tcnt, tcnt_n;

    // cfg_ready is the only combinational output and depends on state alone
    assign cfg_ready = (state == LOAD);

    // Next-state, shift register and counter update
    always_comb begin
        state_n = state;
        sr_n    = sr;
        bcnt_n  = bcnt;
        wcnt_n  = wcnt;
        tcnt_n  = tcnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = LOAD;
                    bcnt_n  = '0;
                    wcnt_n  = '0;
                    tcnt_n  = '0;
                end
            end
            LOAD: begin
                if (cfg_valid) begin
                    sr_n    = cfg_data;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                sr_n   = {sr[WORD_BITS-2:0], 1'b0};
                bcnt_n = bcnt + 4'd1;
                if (bcnt == 4'd15) begin
                    wcnt_n  = wcnt + WCW'(1);
                    state_n = (wcnt == LAST_WORD) ? TOKEN : LOAD;
                end
            end
            TOKEN: begin
                state_n = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (io_prgm_b_out) begin
                    state_n = DONE;
                end else if (tcnt == LAST_WAIT) begin
                    state_n = ERR;
                end else begin
                    tcnt_n = tcnt + TCW'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            ERR: begin
                if (start) begin
                    state_n = LOAD;
                    bcnt_n  = '0;
                    wcnt_n  = '0;
                    tcnt_n  = '0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State register plus outputs registered from the next-state decode,
    // so each output lines up with the state it belongs to
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            sr           <= '0;
            bcnt         <= '0;
            wcnt         <= '0;
            tcnt         <= '0;
            bit_out      <= 1'b0;
            prgm_b       <= 1'b0;
            io_prgm_b    <= 1'b0;
            io_prgm_b_in <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            state        <= state_n;
            sr           <= sr_n;
            bcnt         <= bcnt_n;
            wcnt         <= wcnt_n;
            tcnt         <= tcnt_n;
            io_prgm_b    <= (state_n == SHIFT);
            bit_out      <= (state_n == SHIFT) && sr_n[WORD_BITS-1];
            io_prgm_b_in <= (state_n == TOKEN);
            prgm_b       <= (state_n == LOAD) || (state_n == SHIFT) ||
                            (state_n == TOKEN) || (state_n == WAIT_ACK) ||
                            (state_n == DONE);
            busy         <= (state_n == LOAD) || (state_n == SHIFT) ||
                            (state_n == TOKEN) || (state_n == WAIT_ACK);
            done         <= (state_n == DONE);
            error        <= (state_n == ERR);
        end
    end

endmodule
